// File: rtl/ripple_carry_counter.sv
// Ripple up-counter: chain of falling-edge toggle stages, async active-low reset.
// Optional terminal-count flop behind `RCC_CARRY_OUT_EN.
module ripple_carry_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] q
`ifdef RCC_CARRY_OUT_EN
   ,
   output logic             carry_out
`endif
);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i = i + 1) begin : g_stage
         logic s;
         if (i == 0) begin : g_first
            always_ff @(negedge clk or negedge reset) begin
               if (!reset) s <= 1'b0;
               else        s <= ~s;
            end
         end else begin : g_next
            // each upper stage is clocked by the falling edge of the bit below
            always_ff @(negedge q[i-1] or negedge reset) begin
               if (!reset) s <= 1'b0;
               else        s <= ~s;
            end
         end
         assign q[i] = s;
      end
   endgenerate

`ifdef RCC_CARRY_OUT_EN
   // samples q before the ripple updates it, so all-ones here marks the wrap edge
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) carry_out <= 1'b0;
      else        carry_out <= &q;
   end
`endif

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Scoreboard bench for ripple_carry_counter (WIDTH=4): a reference model pushes
// expected {carry,q} at each clk falling edge; a checker pops and compares 1 time unit later.
module tb_ripple_carry_counter;

   localparam int unsigned W = 4;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] q;
   logic         carry;

`ifdef RCC_CARRY_OUT_EN
   ripple_carry_counter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .q(q), .carry_out(carry));
`else
   ripple_carry_counter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .q(q));
   assign carry = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [W:0] sb[$];
   int unsigned mcount = 0;
   logic        mcarry = 1'b0;
   bit          armed  = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // reference model
   always @(negedge reset) begin
      mcount = 0;
      mcarry = 1'b0;
   end

   always @(negedge clk) begin
      if (!reset) begin
         mcount = 0;
         mcarry = 1'b0;
      end else begin
         mcarry = (mcount == (1 << W) - 1);
         mcount = (mcount + 1) % (1 << W);
      end
      sb.push_back({mcarry, mcount[W-1:0]});
   end

   // falling-edge checker
   always @(negedge clk) begin
      logic [W:0] e;
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("q_fall", 32'(q), 32'(e[W-1:0]));
`ifdef RCC_CARRY_OUT_EN
         chk("carry_fall", 32'(carry), 32'(e[W]));
`endif
      end
   end

   // rising edges must leave the count unchanged
   always @(posedge clk) begin
      #1;
      if (armed) begin
         chk("q_rise", 32'(q), mcount);
`ifdef RCC_CARRY_OUT_EN
         chk("carry_rise", 32'(carry), 32'(mcarry));
`endif
      end
   end

   initial begin
      reset = 1'b0;
      #1;
      chk("reset_q", 32'(q), 32'd0);
      chk("reset_carry", 32'(carry), 32'd0);
      #14 reset = 1'b1;            // t=15
      armed = 1'b1;
      #180 reset = 1'b0;           // t=195, mid-count
      #1;
      chk("midreset_q", 32'(q), 32'd0);
      chk("midreset_carry", 32'(carry), 32'd0);
      #9 reset = 1'b1;             // t=205
      #156;                        // t=361, just after wrap at t=360
      chk("wrap_q", 32'(q), 32'd0);
`ifdef RCC_CARRY_OUT_EN
      chk("wrap_carry", 32'(carry), 32'd1);
`endif
      #2 reset = 1'b0;             // t=363, inside the carry period
      #1;
      chk("carryreset_q", 32'(q), 32'd0);
      chk("carryreset_carry", 32'(carry), 32'd0);
      #11 reset = 1'b1;            // t=375
      #50;                         // t=425
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
